// File: rtl/seq_alu.sv
// seq_alu: sequential ALU. Logic/arithmetic/compare opcodes complete in one
// cycle; MULTU (shift-add) and DIVU (restoring) iterate one bit per cycle.
// FSM: IDLE -> (DONE | BUSY) -> DONE -> IDLE, with back-to-back issue from DONE.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             is_div_reg, is_div_next;
  // Iteration working set: for MULTU {work_hi,work_lo} is the partial
  // product with the multiplier shifting out of work_lo; for DIVU work_hi is
  // the partial remainder and work_lo the dividend/quotient shift register.
  logic [WIDTH-1:0] work_hi_reg, work_hi_next;
  logic [WIDTH-1:0] work_lo_reg, work_lo_next;
  logic [WIDTH-1:0] opnd_reg, opnd_next;

  // Bitwise operations, one cell per bit
  logic [WIDTH-1:0] and_v, or_v, nor_v;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_v[gi] = a[gi] & b[gi];
      assign or_v[gi]  = a[gi] | b[gi];
      assign nor_v[gi] = ~(a[gi] | b[gi]);
    end
  endgenerate

  logic [WIDTH-1:0] add_v, sub_v;
  logic             slt_v, sltu_v;
  assign add_v  = a + b;
  assign sub_v  = a - b;
  assign slt_v  = $signed(a) < $signed(b);
  assign sltu_v = a < b;

  logic             single_valid;
  logic [WIDTH-1:0] single_val;

  // Single-cycle opcode decode; undefined opcodes leave result untouched
  always_comb begin
    single_valid = 1'b1;
    single_val   = '0;
    case (alu_ctrl)
      OP_AND:  single_val = and_v;
      OP_OR:   single_val = or_v;
      OP_ADD:  single_val = add_v;
      OP_SUB:  single_val = sub_v;
      OP_SLT:  single_val = {{(WIDTH-1){1'b0}}, slt_v};
      OP_SLTU: single_val = {{(WIDTH-1){1'b0}}, sltu_v};
      OP_NOR:  single_val = nor_v;
      default: single_valid = 1'b0;
    endcase
  end

  // One shift-add multiply step: add multiplicand when LSB set, then shift right
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  always_comb begin
    mul_sum = {1'b0, work_hi_reg} + {1'b0, opnd_reg};
    if (work_lo_reg[0])
      {mul_hi_n, mul_lo_n} = {mul_sum, work_lo_reg[WIDTH-1:1]};
    else
      {mul_hi_n, mul_lo_n} = {1'b0, work_hi_reg, work_lo_reg[WIDTH-1:1]};
  end

  // One restoring-divide step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  always_comb begin
    div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_ge    = div_shift >= {1'b0, opnd_reg};
    div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_n  = {work_lo_reg[WIDTH-2:0], div_ge};
  end

  logic [WIDTH-1:0] step_hi, step_lo;
  assign step_hi = is_div_reg ? div_hi_n : mul_hi_n;
  assign step_lo = is_div_reg ? div_lo_n : mul_lo_n;

  // Next-state and datapath update
  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    hi_next      = hi_reg;
    cnt_next     = cnt_reg;
    is_div_next  = is_div_reg;
    work_hi_next = work_hi_reg;
    work_lo_next = work_lo_reg;
    opnd_next    = opnd_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          if (alu_ctrl == OP_MULTU) begin
            work_hi_next = '0;
            work_lo_next = a;
            opnd_next    = b;
            is_div_next  = 1'b0;
            cnt_next     = CW'(WIDTH);
            state_next   = BUSY;
          end else if (alu_ctrl == OP_DIVU) begin
            if (b == '0) begin
              // Divide by zero short-circuits: no iteration at all
              result_next = '1;
              hi_next     = a;
              state_next  = DONE;
            end else begin
              work_hi_next = '0;
              work_lo_next = a;
              opnd_next    = b;
              is_div_next  = 1'b1;
              cnt_next     = CW'(WIDTH);
              state_next   = BUSY;
            end
          end else begin
            if (single_valid)
              result_next = single_val;
            state_next = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        work_hi_next = step_hi;
        work_lo_next = step_lo;
        cnt_next     = cnt_reg - 1'b1;
        // Outputs are only written on the final step so partial values never show
        if (cnt_reg == CW'(1)) begin
          result_next = step_lo;
          hi_next     = step_hi;
          state_next  = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      result_reg  <= '0;
      hi_reg      <= '0;
      cnt_reg     <= '0;
      is_div_reg  <= 1'b0;
      work_hi_reg <= '0;
      work_lo_reg <= '0;
      opnd_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      hi_reg      <= hi_next;
      cnt_reg     <= cnt_next;
      is_div_reg  <= is_div_next;
      work_hi_reg <= work_hi_next;
      work_lo_reg <= work_lo_next;
      opnd_reg    <= opnd_next;
    end
  end

  assign busy   = (state_reg == BUSY);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign hi     = hi_reg;
  assign zero   = (result_reg == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH 8, 32 and 64.
module tb_seq_alu;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_UNDEF = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ctrl = '0;
  logic [63:0] opa = '0, opb = '0;
  logic        st8 = 1'b0, st32 = 1'b0, st64 = 1'b0;

  logic        busy8, done8, zero8, busy32, done32, zero32, busy64, done64, zero64;
  logic [7:0]  res8, hi8;
  logic [31:0] res32, hi32;
  logic [63:0] res64, hi64;

  int errors = 0;
  int checks = 0;
  int cur_w  = 32;

  logic [63:0] m_r [3];
  logic [63:0] m_h [3];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .alu_ctrl(ctrl), .a(opa[7:0]), .b(opb[7:0]),
    .busy(busy8), .done(done8), .result(res8), .hi(hi8), .zero(zero8));
  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .alu_ctrl(ctrl), .a(opa[31:0]), .b(opb[31:0]),
    .busy(busy32), .done(done32), .result(res32), .hi(hi32), .zero(zero32));
  seq_alu #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(st64), .alu_ctrl(ctrl), .a(opa), .b(opb),
    .busy(busy64), .done(done64), .result(res64), .hi(hi64), .zero(zero64));

  logic        cur_busy, cur_done, cur_zero;
  logic [63:0] cur_res, cur_hi;
  always_comb begin
    cur_busy = busy32; cur_done = done32; cur_zero = zero32;
    cur_res  = {32'b0, res32}; cur_hi = {32'b0, hi32};
    if (cur_w == 8) begin
      cur_busy = busy8; cur_done = done8; cur_zero = zero8;
      cur_res  = {56'b0, res8}; cur_hi = {56'b0, hi8};
    end else if (cur_w == 64) begin
      cur_busy = busy64; cur_done = done64; cur_zero = zero64;
      cur_res  = res64; cur_hi = hi64;
    end
  end

  function automatic int widx(input int w);
    return (w == 8) ? 0 : (w == 32) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    st8  = v && (w == 8);
    st32 = v && (w == 32);
    st64 = v && (w == 64);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_r[i] = '0;
      m_h[i] = '0;
    end
  endtask

  // Reference model: expected result/hi/latency given prior architectural state
  task automatic ref_op(input int w, input logic [3:0] op, input logic [63:0] x, y,
                        output logic [63:0] er, output logic [63:0] eh, output int elat);
    logic [63:0]  mask, xm, ym;
    logic [127:0] p;
    logic         sx, sy;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm = x & mask;
    ym = y & mask;
    er = m_r[widx(w)];
    eh = m_h[widx(w)];
    elat = 1;
    sx = xm[w-1];
    sy = ym[w-1];
    case (op)
      OP_AND:  er = xm & ym;
      OP_OR:   er = xm | ym;
      OP_ADD:  er = (xm + ym) & mask;
      OP_SUB:  er = (xm - ym) & mask;
      OP_SLT:  er = (sx != sy) ? {63'b0, sx} : {63'b0, xm < ym};
      OP_SLTU: er = {63'b0, xm < ym};
      OP_NOR:  er = ~(xm | ym) & mask;
      OP_MULTU: begin
        p = {64'b0, xm} * {64'b0, ym};
        er = p[63:0] & mask;
        eh = p[127:64] << (64 - w) | (p[63:0] >> w);
        eh = eh & mask;
        elat = w + 1;
      end
      OP_DIVU: begin
        if (ym == 0) begin
          er = mask;
          eh = xm;
        end else begin
          er = xm / ym;
          eh = xm % ym;
          elat = w + 1;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one operation, wait for done (bounded), check outputs and timing
  task automatic do_op(input string tag, input int w, input logic [3:0] op,
                       input logic [63:0] x, y, input bit poke,
                       input logic [63:0] er, eh, input int elat);
    int lat, bcnt;
    cur_w = w;
    @(negedge clk);
    ctrl = op; opa = x; opb = y;
    set_start(w, 1'b1);
    lat = 0;
    bcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      set_start(w, 1'b0);
      if (poke && (lat == 5 || lat == 6)) begin
        set_start(w, 1'b1);
        ctrl = OP_ADD; opa = ~x; opb = 64'd7;
      end
      if (cur_busy) bcnt++;
      if (cur_done) break;
    end
    check({tag, ".done"}, {63'b0, cur_done}, 64'd1);
    check({tag, ".lat"}, 64'(lat), 64'(elat));
    check({tag, ".busycyc"}, 64'(bcnt), 64'(elat - 1));
    check({tag, ".busy_at_done"}, {63'b0, cur_busy}, 64'd0);
    check({tag, ".result"}, cur_res, er);
    check({tag, ".hi"}, cur_hi, eh);
    check({tag, ".zero"}, {63'b0, cur_zero}, {63'b0, er == 0});
    $display("op w=%0d ctrl=%b a=%0h b=%0h -> result=%0h hi=%0h lat=%0d", w, op, x, y, cur_res, cur_hi, lat);
    m_r[widx(w)] = er;
    m_h[widx(w)] = eh;
  endtask

  task automatic do_model(input string tag, input int w, input logic [3:0] op, input logic [63:0] x, y);
    logic [63:0] er, eh;
    int elat;
    ref_op(w, op, x, y, er, eh, elat);
    do_op(tag, w, op, x, y, 1'b0, er, eh, elat);
  endtask

  logic [3:0] ops [10];
  bit         saw_done;

  initial begin
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_NOR, OP_MULTU, OP_DIVU, OP_UNDEF};
    do_reset();

    // Reset state on every instance
    for (int k = 0; k < 3; k++) begin
      cur_w = (k == 0) ? 8 : (k == 1) ? 32 : 64;
      #1;
      check("rst.result", cur_res, 64'd0);
      check("rst.hi", cur_hi, 64'd0);
      check("rst.zero", {63'b0, cur_zero}, 64'd1);
      check("rst.busy", {63'b0, cur_busy}, 64'd0);
      check("rst.done", {63'b0, cur_done}, 64'd0);
    end

    // Hand-computed WIDTH=32 vectors
    do_op("add_wrap", 32, OP_ADD, 64'hFFFF_FFFF, 64'h1, 1'b0, 64'h0, 64'h0, 1);
    do_op("slt", 32, OP_SLT, 64'hFFFF_FFFE, 64'h1, 1'b0, 64'h1, 64'h0, 1);
    do_op("sltu", 32, OP_SLTU, 64'hFFFF_FFFE, 64'h1, 1'b0, 64'h0, 64'h0, 1);
    do_op("multu_max", 32, OP_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1,
          64'h0000_0001, 64'hFFFF_FFFE, 33);
    do_op("divu_100_7", 32, OP_DIVU, 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 33);
    do_op("divu_by0", 32, OP_DIVU, 64'd5, 64'd0, 1'b0, 64'hFFFF_FFFF, 64'd5, 1);
    do_op("sub_wrap", 32, OP_SUB, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFE, 64'd5, 1);
    do_op("nor", 32, OP_NOR, 64'hF0F0_0000, 64'h0000_0F0F, 1'b0, 64'h0F0F_F0F0, 64'd5, 1);
    do_op("undef", 32, OP_UNDEF, 64'd9, 64'd9, 1'b0, 64'h0F0F_F0F0, 64'd5, 1);

    // Reset in the middle of a multiply aborts it silently
    cur_w = 32;
    saw_done = 1'b0;
    @(negedge clk);
    ctrl = OP_MULTU; opa = 64'hFFFF_FFFF; opb = 64'hFFFF_FFFF;
    set_start(32, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      set_start(32, 1'b0);
      if (cur_done) saw_done = 1'b1;
    end
    rst = 1'b1;
    set_start(32, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    set_start(32, 1'b0);
    if (cur_done) saw_done = 1'b1;
    check("abort.no_done", {63'b0, saw_done}, 64'd0);
    check("abort.result", cur_res, 64'd0);
    check("abort.hi", cur_hi, 64'd0);
    check("abort.busy", {63'b0, cur_busy}, 64'd0);
    $display("abort w=32 result=%0h hi=%0h busy=%0b", cur_res, cur_hi, cur_busy);
    for (int i = 0; i < 3; i++) begin
      m_r[i] = '0;
      m_h[i] = '0;
    end
    do_op("add_after_abort", 32, OP_ADD, 64'd2, 64'd3, 1'b0, 64'd5, 64'd0, 1);

    // Back-to-back: start held through the done cycle
    cur_w = 32;
    @(negedge clk);
    ctrl = OP_OR; opa = 64'hF0; opb = 64'h0F;
    set_start(32, 1'b1);
    @(negedge clk);
    check("b2b.done1", {63'b0, cur_done}, 64'd1);
    check("b2b.res1", cur_res, 64'hFF);
    ctrl = OP_AND; opa = 64'hF0F0; opb = 64'hFF00;
    @(negedge clk);
    set_start(32, 1'b0);
    check("b2b.done2", {63'b0, cur_done}, 64'd1);
    check("b2b.res2", cur_res, 64'hF000);
    @(negedge clk);
    check("b2b.idle", {63'b0, cur_done}, 64'd0);
    $display("b2b w=32 result=%0h", cur_res);
    m_r[1] = 64'hF000;

    // Model-based sweep at WIDTH 8 and 64
    for (int k = 0; k < 2; k++) begin
      for (int v = 0; v < 3; v++) begin
        for (int j = 0; j < 10; j++) begin
          logic [63:0] x, y;
          if (v == 0) begin
            x = '1; y = '1;
          end else if (v == 1) begin
            x = {$urandom, $urandom}; y = 64'd0;
          end else begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom} >> $urandom_range(0, 60);
          end
          do_model("sweep", (k == 0) ? 8 : 64, ops[j], x, y);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be supported for any value from 8 to 64.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port start  input  1  operation request, sampled on clk.
REQ-005 Port alu_ctrl  input  4  opcode, sampled with start.
REQ-006 Port a  input  WIDTH  operand A, sampled with start.
REQ-007 Port b  input  WIDTH  operand B, sampled with start.
REQ-008 Port busy  output  1  high while an iterative operation is in progress.
REQ-009 Port done  output  1  one-cycle pulse; result/hi valid in that cycle.
REQ-010 Port result  output  WIDTH  registered primary result.
REQ-011 Port hi  output  WIDTH  registered secondary result (product high half / remainder).
REQ-012 Port zero  output  1  high when result equals 0, combinational from the result register.

Function
REQ-013 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU (unsigned), 1100 NOR, 0011 MULTU, 0100 DIVU.
REQ-014 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-015 SLT/SLTU SHALL write 1 or 0 zero-extended to WIDTH.
REQ-016 FSM SHALL have states IDLE, BUSY, DONE; reset state IDLE.
REQ-017 IDLE/DONE + start + single-cycle opcode: the next state is DONE, result written at that edge, done=1 the following cycle (latency 1); hi unchanged.
REQ-018 IDLE/DONE + start + MULTU/DIVU: operands latched, the next state is BUSY, busy=1, iteration counter loaded with WIDTH.
REQ-019 BUSY: one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle; after exactly WIDTH steps, DONE; total start-to-done latency WIDTH+1 cycles.
REQ-020 MULTU: unsigned, {hi,result} = a*b, full 2*WIDTH product.
REQ-021 DIVU: unsigned, result = a/b, hi = a%b.
REQ-022 DIVU with b=0: no iteration; DONE after 1 cycle with result = all ones and hi = a.
REQ-023 DONE lasts exactly one cycle (done=1), then returns to IDLE unless start is high, in which case the new operation is accepted (back-to-back issue).
REQ-024 start while BUSY SHALL be ignored; operands, opcode and in-flight computation unaffected.
REQ-025 Undefined opcode: accepted as single-cycle, done pulses at latency 1, result and hi keep previous values.
REQ-026 result and hi SHALL hold their value from done until the next completing operation; intermediate iteration values SHALL NOT appear on result/hi while busy.
REQ-027 busy=1 exactly in BUSY; done=1 exactly in DONE; never both high.

Reset
REQ-028 rst=1 at a clk edge SHALL force IDLE, busy=0, done=0, result=0, hi=0, counter=0; zero therefore 1.
REQ-029 rst asserted mid-BUSY SHALL abort the operation with no done pulse; rst has priority over start.

Verification
REQ-030 Reset, then start ADD a=0xFFFFFFFF b=0x1 (WIDTH=32) -> done next cycle, result=0x0, zero=1.
REQ-031 SLT a=0xFFFFFFFE b=0x1 -> result=1; SLTU same operands -> result=0.
REQ-032 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 32 cycles, done at cycle 33, hi=0xFFFFFFFE, result=0x00000001; start pulses during busy ignored.
REQ-033 DIVU a=100 b=7 -> done at cycle 33, result=14, hi=2; DIVU a=5 b=0 -> done at cycle 1, result=0xFFFFFFFF, hi=5.
REQ-034 rst asserted at cycle 10 of a MULTU -> no done pulse, result=0, hi=0, busy=0; new ADD 2+3 afterwards -> result=5.
REQ-035 Back-to-back: start held through done of OR 0xF0|0x0F then AND -> done pulses on consecutive operations, results 0xFF then correct AND value; repeat full regression at WIDTH=8 and WIDTH=64 against a reference model.
